servo_pwm_ctrl: RTL and testbench

//  Consumes joystick X position (0-1023) and produces one hobby-servo PWM output.

---
 rtl/servo_pkg.sv | 40 ++++
 rtl/servo_target_map.sv | 35 +++
 rtl/servo_pwm_ctrl.sv | 95 +++++++++
 tb/tb_servo_pwm_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and slew helper for the joystick-driven servo PWM block.
// Default timing assumes the 25 MHz CLK domain of the joystick SPI reader.
package servo_pkg;

   localparam int unsigned CLK_HZ         = 25_000_000;
   localparam int unsigned PERIOD_CLKS    = 500_000;
   localparam int unsigned MIN_PULSE_CLKS = 25_000;
   localparam int unsigned STEP_CLKS      = 24;
   localparam int unsigned MAX_PULSE_CLKS = 50_000;
   localparam int unsigned DEADZONE       = 16;
   localparam int unsigned SLEW_CLKS      = 500;
   localparam int unsigned CENTER_CLKS    = MIN_PULSE_CLKS + 512 * STEP_CLKS;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_ARM   = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } servo_state_t;

   function automatic int unsigned center_of(input int unsigned min_pulse,
                                             input int unsigned step);
      return min_pulse + 512 * step;
   endfunction

   // Moves width toward target by at most limit; the last step lands exactly on target.
   function automatic logic [15:0] slew_step(input logic [15:0] width,
                                             input logic [15:0] target,
                                             input logic [15:0] limit);
      logic [15:0] diff;
      if (target > width) begin
         diff = target - width;
         slew_step = width + ((diff > limit) ? limit : diff);
      end else begin
         diff = width - target;
         slew_step = width - ((diff > limit) ? limit : diff);
      end
   endfunction

endpackage

// File: rtl/servo_target_map.sv
// Combinational map from the 10-bit joystick position to a pulse-width target,
// snapping the centre deadzone to the neutral width and clamping at the top end.
module servo_target_map
   import servo_pkg::*;
#(
   parameter int unsigned MIN_PULSE = MIN_PULSE_CLKS,
   parameter int unsigned STEP      = STEP_CLKS,
   parameter int unsigned MAX_PULSE = MAX_PULSE_CLKS,
   parameter int unsigned DZONE     = DEADZONE
)
(
   input  logic [9:0]  x10,
   output logic [15:0] target
);

   localparam logic [15:0] CENTER = 16'(center_of(MIN_PULSE, STEP));

   logic signed [10:0] d;
   logic [10:0]        abs_d;
   logic [31:0]        raw;

   // The linear width is formed in 32 bits so the clamp sees the true value.
   always_comb begin
      d      = $signed({1'b0, x10}) - 11'sd512;
      abs_d  = d[10] ? 11'(-d) : 11'(d);
      raw    = 32'(MIN_PULSE) + 32'(x10) * 32'(STEP);
      target = raw[15:0];
      if (abs_d <= 11'(DZONE)) begin
         target = CENTER;
      end else if (raw > 32'(MAX_PULSE)) begin
         target = 16'(MAX_PULSE);
      end
   end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Hobby-servo PWM generator: free-running frame counter, once-per-frame slewed width
// update and an enable FSM that only starts or stops the pulse train on frame boundaries.
module servo_pwm_ctrl
   import servo_pkg::*;
#(
   parameter int unsigned PERIOD    = PERIOD_CLKS,
   parameter int unsigned MIN_PULSE = MIN_PULSE_CLKS,
   parameter int unsigned STEP      = STEP_CLKS,
   parameter int unsigned MAX_PULSE = MAX_PULSE_CLKS,
   parameter int unsigned DZONE     = DEADZONE,
   parameter int unsigned SLEW      = SLEW_CLKS
)
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] x_pos,
   input  logic        i_Enable,
   input  logic        i_Hold,
   output logic        o_PWM,
   output logic [15:0] o_Pulse_Clks,
   output logic        o_Frame_Start
);

   localparam int          CNT_W  = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
   localparam logic [15:0] CENTER = 16'(center_of(MIN_PULSE, STEP));

   logic [CNT_W-1:0] cnt;
   servo_state_t     state;
   logic             frame_end;
   logic [15:0]      map_target;
   logic [15:0]      target;
   logic             x_unused_bits;

   assign x_unused_bits = ^x_pos[31:10];
   assign frame_end     = (cnt == LAST);
   assign target        = i_Hold ? o_Pulse_Clks : map_target;

   servo_target_map #(
      .MIN_PULSE (MIN_PULSE),
      .STEP      (STEP),
      .MAX_PULSE (MAX_PULSE),
      .DZONE     (DZONE)
   ) u_target_map (
      .x10    (x_pos[9:0]),
      .target (map_target)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (frame_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Enable changes are resolved first; a change on the last cycle still takes the frame transition.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= S_OFF;
         o_PWM         <= 1'b0;
         o_Pulse_Clks  <= CENTER;
         o_Frame_Start <= 1'b0;
      end else begin
         case (state)
            S_OFF: begin
               if (i_Enable) state <= frame_end ? S_RUN : S_ARM;
            end
            S_ARM: begin
               if (!i_Enable)     state <= S_OFF;
               else if (frame_end) state <= S_RUN;
            end
            S_RUN: begin
               if (!i_Enable) state <= frame_end ? S_OFF : S_DRAIN;
            end
            S_DRAIN: begin
               if (i_Enable)       state <= S_RUN;
               else if (frame_end) state <= S_OFF;
            end
            default: state <= S_OFF;
         endcase

         o_PWM         <= ((state == S_RUN) || (state == S_DRAIN)) &&
                          (32'(cnt) < 32'(o_Pulse_Clks));
         o_Frame_Start <= frame_end;

         if (frame_end) begin
            o_Pulse_Clks <= slew_step(o_Pulse_Clks, target, 16'(SLEW));
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Self-checking bench for servo_pwm_ctrl with shortened frame timing; a frame-level
// reference model predicts width, pulse presence and strobe for every frame.
module tb_servo_pwm_ctrl;

   localparam int P      = 1200;
   localparam int MINP   = 20;
   localparam int STEP   = 2;
   localparam int MAXP   = 1100;
   localparam int DZ     = 16;
   localparam int SL     = 40;
   localparam int CENTER = MINP + 512 * STEP;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] x_pos = 32'd512;
   logic        i_Enable = 1'b0;
   logic        i_Hold = 1'b0;
   logic        o_PWM;
   logic [15:0] o_Pulse_Clks;
   logic        o_Frame_Start;

   int checks = 0;
   int passed = 0;
   int m_width;
   bit m_pulsing;
   bit m_first;

   servo_pwm_ctrl #(
      .PERIOD    (P),
      .MIN_PULSE (MINP),
      .STEP      (STEP),
      .MAX_PULSE (MAXP),
      .DZONE     (DZ),
      .SLEW      (SL)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .x_pos         (x_pos),
      .i_Enable      (i_Enable),
      .i_Hold        (i_Hold),
      .o_PWM         (o_PWM),
      .o_Pulse_Clks  (o_Pulse_Clks),
      .o_Frame_Start (o_Frame_Start)
   );

   always #5 CLK = ~CLK;

   function automatic int model_target(input int x, input bit hold, input int w);
      int d;
      int t;
      if (hold) return w;
      d = x - 512;
      if (d < 0) d = -d;
      if (d <= DZ) return CENTER;
      t = MINP + x * STEP;
      return (t > MAXP) ? MAXP : t;
   endfunction

   function automatic int model_slew(input int w, input int t);
      if (t > w) return (t - w > SL) ? w + SL : t;
      if (t < w) return (w - t > SL) ? w - SL : t;
      return w;
   endfunction

   task automatic model_reset();
      m_width   = CENTER;
      m_pulsing = 1'b0;
      m_first   = 1'b1;
   endtask

   // One full frame starting at counter phase 0; enable may change at up to two phases.
   task automatic run_frame(input string name, input int x10, input bit en0, input bit hold,
                            input int cpa, input bit ena, input int cpb, input bit enb);
      int w_exp;
      bit puls;
      bit exp_pwm;
      bit fs0;
      bit en_final;
      int highs;
      int shape_err;
      int width_err;
      int fs_err;
      w_exp     = m_width;
      puls      = m_pulsing;
      highs     = 0;
      shape_err = 0;
      width_err = 0;
      fs_err    = 0;
      fs0       = 1'b0;
      for (int p = 0; p < P; p++) begin
         @(negedge CLK);
         if (p == 0) begin
            x_pos    = {22'($urandom()), 10'(x10)};
            i_Enable = en0;
            i_Hold   = hold;
         end
         if (p == cpa) i_Enable = ena;
         if (p == cpb) i_Enable = enb;
         exp_pwm = puls && (p >= 1) && (p <= w_exp);
         if (o_PWM !== exp_pwm) shape_err++;
         if (o_PWM === 1'b1) highs++;
         if (o_Pulse_Clks !== 16'(w_exp)) width_err++;
         if (p == 0) fs0 = o_Frame_Start;
         else if (o_Frame_Start !== 1'b0) fs_err++;
      end
      checks++;
      if (highs != (puls ? w_exp : 0))
         $display("[TB] FAIL %s pulse_len: got %0d expected %0d", name, highs, puls ? w_exp : 0);
      else passed++;
      checks++;
      if (shape_err != 0)
         $display("[TB] FAIL %s pwm_shape: got %0d bad cycles expected 0", name, shape_err);
      else passed++;
      checks++;
      if (width_err != 0)
         $display("[TB] FAIL %s pulse_clks: got %0d (first sample) bad %0d expected %0d",
                  name, o_Pulse_Clks, width_err, w_exp);
      else passed++;
      checks++;
      if (fs0 !== !m_first)
         $display("[TB] FAIL %s frame_start_p0: got %0b expected %0b", name, fs0, !m_first);
      else passed++;
      checks++;
      if (fs_err != 0)
         $display("[TB] FAIL %s frame_start_extra: got %0d expected 0", name, fs_err);
      else passed++;
      en_final = en0;
      if (cpa >= 0) en_final = ena;
      if (cpb >= 0) en_final = enb;
      m_width   = model_slew(w_exp, model_target(x10, hold, w_exp));
      m_pulsing = en_final;
      m_first   = 1'b0;
   endtask

   task automatic frame(input string name, input int x10, input bit en, input bit hold);
      run_frame(name, x10, en, hold, -1, 1'b0, -1, 1'b0);
   endtask

   task automatic test_reset();
      #1 RST = 1'b1;
      #3;
      checks++;
      if (o_PWM !== 1'b0) $display("[TB] FAIL rst_pwm: got %b expected 0", o_PWM);
      else passed++;
      checks++;
      if (o_Pulse_Clks !== 16'(CENTER))
         $display("[TB] FAIL rst_width: got %0d expected %0d", o_Pulse_Clks, CENTER);
      else passed++;
      checks++;
      if (o_Frame_Start !== 1'b0) $display("[TB] FAIL rst_fs: got %b expected 0", o_Frame_Start);
      else passed++;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      model_reset();
   endtask

   task automatic test_enable_mid_frame();
      run_frame("en_mid", 512, 1'b0, 1'b0, 500, 1'b1, -1, 1'b0);
      frame("en_run1", 512, 1'b1, 1'b0);
      frame("en_run2", 512, 1'b1, 1'b0);
   endtask

   task automatic test_slew_to_max();
      for (int i = 0; i < 4; i++) frame($sformatf("slew_up%0d", i), 1023, 1'b1, 1'b0);
   endtask

   task automatic test_deadzone();
      frame("dz_back0", 512, 1'b1, 1'b0);
      frame("dz_back1", 512, 1'b1, 1'b0);
      frame("dz_520", 520, 1'b1, 1'b0);
      frame("dz_528", 528, 1'b1, 1'b0);
      frame("dz_529", 529, 1'b1, 1'b0);
      frame("dz_496", 496, 1'b1, 1'b0);
      frame("dz_495", 495, 1'b1, 1'b0);
      frame("dz_settle", 512, 1'b1, 1'b0);
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) frame($sformatf("hold%0d", i), 0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) frame($sformatf("release%0d", i), 0, 1'b1, 1'b0);
   endtask

   task automatic test_drain();
      run_frame("drain_drop", 512, 1'b1, 1'b0, 300, 1'b0, -1, 1'b0);
      frame("drain_off", 512, 1'b0, 1'b0);
      frame("drain_arm", 512, 1'b1, 1'b0);
      run_frame("drain_reen", 512, 1'b1, 1'b0, 300, 1'b0, 900, 1'b1);
      frame("drain_after", 512, 1'b1, 1'b0);
   endtask

   task automatic test_boundary();
      run_frame("bnd_off_last", 512, 1'b1, 1'b0, P - 1, 1'b0, -1, 1'b0);
      run_frame("bnd_on_last", 512, 1'b0, 1'b0, P - 1, 1'b1, -1, 1'b0);
      frame("bnd_run", 600, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int x;
      bit en;
      bit hold;
      int cpa;
      for (int i = 0; i < 14; i++) begin
         if ($urandom_range(0, 3) == 0) x = 512 - 20 + $urandom_range(0, 40);
         else x = $urandom_range(0, 1023);
         en   = ($urandom_range(0, 3) != 0);
         hold = ($urandom_range(0, 3) == 0);
         cpa  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, P - 1) : -1;
         run_frame($sformatf("rand%0d", i), x, en, hold, cpa, $urandom_range(0, 1) == 1, -1, 1'b0);
      end
   endtask

   task automatic test_reset_mid_pulse();
      frame("pre_rst", 512, 1'b1, 1'b0);
      for (int p = 0; p <= m_width / 2; p++) @(negedge CLK);
      checks++;
      if (o_PWM !== 1'b1) $display("[TB] FAIL midrst_pre_pwm: got %b expected 1", o_PWM);
      else passed++;
      #1 RST = 1'b1;
      #1;
      checks++;
      if (o_PWM !== 1'b0) $display("[TB] FAIL midrst_pwm: got %b expected 0", o_PWM);
      else passed++;
      checks++;
      if (o_Pulse_Clks !== 16'(CENTER))
         $display("[TB] FAIL midrst_width: got %0d expected %0d", o_Pulse_Clks, CENTER);
      else passed++;
      checks++;
      if (o_Frame_Start !== 1'b0) $display("[TB] FAIL midrst_fs: got %b expected 0", o_Frame_Start);
      else passed++;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      model_reset();
      frame("post_rst0", 700, 1'b1, 1'b0);
      frame("post_rst1", 700, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_enable_mid_frame();
      test_slew_to_max();
      test_deadzone();
      test_hold();
      test_drain();
      test_boundary();
      test_random();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
